// File: rtl/genetico_pipe.sv
// genetico_pipe - pipelined evolvable-logic array.
//
// N_LE two-input logic elements plus N_OUT output selectors. Each one picks its
// operands from a shared signal index space. A configuration ("chromosome") is
// loaded word-serially into a shadow register. It is then committed atomically
// to the active register once no vector is between stage 1 and stage 2.
// Vectors flow through a 2-stage valid/ready pipeline. Every result carries the
// generation tag of the configuration that was active when it was accepted.
//
// Signal index space: 0..N_IN-1 are the stage-1 input bits; N_IN+k is LE k.
// LE k can only see indices below N_IN+k. Anything else reads 0, so the network
// is feed-forward by construction.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   cfg_start              begin/restart a configuration load
//   cfg_word/valid/ready   configuration word stream (valid/ready)
//   cfg_done               one-cycle pulse when the shadow is committed
//   cfg_gen                generation of the active configuration
//   in_valid/ready         input vector handshake, data on chrom_in
//   out_valid/ready        result handshake, data on chrom_out, tag on out_gen
module genetico_pipe #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 8,
  parameter int N_LE  = 25,
  parameter int SEL_W = 6,
  parameter int CFG_W = 16,
  parameter int GEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [CFG_W-1:0] cfg_word,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic [GEN_W-1:0] cfg_gen,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  chrom_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] chrom_out,
  output logic [GEN_W-1:0] out_gen
);

  localparam int REC      = 3 + 2 * SEL_W;
  localparam int CFG_BITS = N_LE * REC + N_OUT * SEL_W;
  localparam int NWORDS   = (CFG_BITS + CFG_W - 1) / CFG_W;
  localparam int CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int POOL     = 1 << SEL_W;
  localparam int NSIG     = N_IN + N_LE;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

  if (POOL < NSIG) begin : g_sel_w_check
    $error("genetico_pipe: SEL_W too narrow to address N_IN+N_LE signals");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_COMMIT} state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [CNT_W-1:0]     wr_idx;
  logic                 cfg_wr;
  logic [CFG_BITS-1:0]  shadow_bits;
  logic [CFG_BITS-1:0]  active_reg;
  logic [GEN_W-1:0]     gen_reg;

  logic                 s1_valid_reg;
  logic [N_IN-1:0]      s1_data_reg;
  logic [GEN_W-1:0]     s1_gen_reg;
  logic                 out_valid_reg;
  logic [N_OUT-1:0]     chrom_out_reg;
  logic [GEN_W-1:0]     out_gen_reg;
  logic                 s2_free;
  logic [N_OUT-1:0]     net_out;
  logic [POOL-1:0]      out_pool;

  // ---------------------------------------------------------------- loader FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // cfg_start during LOAD restarts at word 0. A word offered in that same
  // cycle is still taken because cfg_ready is high, and it lands in slot 0.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cfg_ready  = 1'b0;
    cfg_done   = 1'b0;
    wr_idx     = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cfg_start) begin
          state_next = ST_LOAD;
          cnt_next   = '0;
        end
      end
      ST_LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_start) begin
          wr_idx   = '0;
          cnt_next = '0;
        end
        if (cfg_valid) begin
          if (wr_idx == LAST_WORD) begin
            state_next = ST_DRAIN;
            cnt_next   = '0;
          end else begin
            cnt_next = wr_idx + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (cfg_start) begin
          state_next = ST_LOAD;
          cnt_next   = '0;
        end else if (!s1_valid_reg) begin
          state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        cfg_done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign cfg_wr = cfg_valid & cfg_ready;

  // Shadow register, one slice per word. The last word keeps only the bits
  // that fall inside the configuration vector.
  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
    localparam int LO = gi * CFG_W;
    localparam int WW = (CFG_BITS - LO < CFG_W) ? (CFG_BITS - LO) : CFG_W;
    logic [WW-1:0] word_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        word_reg <= '0;
      end else if (cfg_wr && (wr_idx == CNT_W'(gi))) begin
        word_reg <= cfg_word[WW-1:0];
      end
    end
    assign shadow_bits[LO +: WW] = word_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_reg <= '0;
      gen_reg    <= '0;
    end else if (state_reg == ST_COMMIT) begin
      active_reg <= shadow_bits;
      gen_reg    <= gen_reg + 1'b1;
    end
  end

  assign cfg_gen = gen_reg;

  // ------------------------------------------------------------------ network
  // Each LE receives the signals below its own index (avail_in). It passes
  // them on with its own output appended. Chaining them this way keeps every
  // net driven by exactly one block.
  for (genvar gi = 0; gi < N_LE; gi++) begin : g_le
    localparam int AW = N_IN + gi;
    logic [AW-1:0]    avail_in;
    logic [AW:0]      avail_out;
    logic [POOL-1:0]  pool;
    logic [2:0]       func;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             op_a;
    logic             op_b;
    logic             y;

    if (gi == 0) begin : g_first
      assign avail_in = s1_data_reg;
    end else begin : g_next
      assign avail_in = g_le[gi-1].avail_out;
    end

    assign {func, sel_a, sel_b} = active_reg[gi*REC +: REC];

    always_comb begin
      pool           = '0;
      pool[AW-1:0]   = avail_in;
      op_a           = pool[sel_a];
      op_b           = pool[sel_b];
      y              = op_a;
      case (func)
        3'd0: y = op_a & op_b;
        3'd1: y = op_a | op_b;
        3'd2: y = op_a ^ op_b;
        3'd3: y = ~(op_a & op_b);
        3'd4: y = ~(op_a | op_b);
        3'd5: y = ~(op_a ^ op_b);
        3'd6: y = ~op_a;
        default: y = op_a;
      endcase
    end

    assign avail_out = {y, avail_in};
  end

  always_comb begin
    out_pool             = '0;
    out_pool[NSIG-1:0]   = g_le[N_LE-1].avail_out;
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
    logic [SEL_W-1:0] osel;
    assign osel        = active_reg[N_LE*REC + gi*SEL_W +: SEL_W];
    assign net_out[gi] = out_pool[osel];
  end

  // ----------------------------------------------------------------- pipeline
  // While loading is draining or committing, no new vector may enter. This
  // guarantees that stage 1 is empty at the moment the active config changes.
  assign s2_free  = !out_valid_reg || out_ready;
  assign in_ready = ((state_reg == ST_IDLE) || (state_reg == ST_LOAD)) &&
                    (!s1_valid_reg || s2_free);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_data_reg   <= '0;
      s1_gen_reg    <= '0;
      out_valid_reg <= 1'b0;
      chrom_out_reg <= '0;
      out_gen_reg   <= '0;
    end else begin
      if (s2_free) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          chrom_out_reg <= net_out;
          out_gen_reg   <= s1_gen_reg;
        end
      end
      if (in_valid && in_ready) begin
        s1_valid_reg <= 1'b1;
        s1_data_reg  <= chrom_in;
        s1_gen_reg   <= gen_reg;
      end else if (s2_free) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign chrom_out = chrom_out_reg;
  assign out_gen   = out_gen_reg;

endmodule

// File: tb/tb_genetico_pipe.sv
// Directed bench for genetico_pipe at default parameters.
module tb_genetico_pipe;

  localparam int NW       = 27;
  localparam int LE_REC   = 15;
  localparam int OUT_BASE = 375;
  localparam int NV       = 40;

  logic        clk;
  logic        rst;
  logic        cfg_start;
  logic [15:0] cfg_word;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_done;
  logic [3:0]  cfg_gen;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  chrom_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  chrom_out;
  logic [3:0]  out_gen;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [431:0] cfg_a, cfg_b, cfg_c;

  genetico_pipe dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_word(cfg_word), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_gen(cfg_gen),
    .in_valid(in_valid), .in_ready(in_ready), .chrom_in(chrom_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .chrom_out(chrom_out), .out_gen(out_gen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (cfg_done === 1'b1) done_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [431:0] le_put(input logic [431:0] v, input int k,
                                          input logic [2:0] f, input logic [5:0] a,
                                          input logic [5:0] b);
    v[k*LE_REC +: LE_REC] = {f, a, b};
    return v;
  endfunction

  function automatic logic [431:0] out_put(input logic [431:0] v, input int j,
                                           input logic [5:0] s);
    v[OUT_BASE + j*6 +: 6] = s;
    return v;
  endfunction

  // Hand-derived transfer functions of configs A and C.
  function automatic logic [7:0] f_a(input logic [7:0] x);
    return {x[7:1], x[0] ^ x[1]};
  endfunction

  function automatic logic [7:0] f_c(input logic [7:0] x);
    return {{5{x[0]}}, 1'b0, x[2] & ~x[3], ~x[2]};
  endfunction

  task automatic run_vec(input logic [7:0] v, input logic [7:0] exp_d,
                         input logic [3:0] exp_g, input string tag);
    int n;
    in_valid = 1'b1;
    chrom_in = v;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check({tag, "_latency"}, n, 1);
    check({tag, "_data"}, 32'(chrom_out), 32'(exp_d));
    check({tag, "_gen"}, 32'(out_gen), 32'(exp_g));
    tick();
    $display("vec %s: in=%02h out=%02h gen=%0d", tag, v, chrom_out, out_gen);
  endtask

  task automatic load_cfg(input logic [431:0] vec, input logic [3:0] exp_g, input string tag);
    int n;
    int d0;
    d0 = done_cnt;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int w = 0; w < NW; w++) begin
      cfg_valid = 1'b1;
      cfg_word  = vec[w*16 +: 16];
      n = 0;
      while (!cfg_ready && n < 20) begin tick(); n++; end
      tick();
    end
    cfg_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check({tag, "_commit_wait"}, 32'(n < 20), 32'd1);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_cfg_gen"}, 32'(cfg_gen), 32'(exp_g));
    $display("load %s: done_pulses=%0d cfg_gen=%0d", tag, done_cnt - d0, cfg_gen);
  endtask

  initial begin : stim
    logic [11:0] expq[$];
    logic [11:0] e;
    logic [7:0]  tmp;
    int          phase, wi, vi, nout, d0;
    logic        loaded, cfg_take, vec_take;

    cfg_a = '0;
    cfg_a = le_put(cfg_a, 0, 3'd2, 6'd0, 6'd1);
    cfg_a = out_put(cfg_a, 0, 6'd8);
    for (int j = 1; j < 8; j++) cfg_a = out_put(cfg_a, j, 6'(j));
    cfg_b = '0;
    cfg_b = le_put(cfg_b, 0, 3'd1, 6'd8, 6'd0);
    cfg_b = out_put(cfg_b, 0, 6'd8);
    cfg_c = '0;
    cfg_c = le_put(cfg_c, 0, 3'd6, 6'd2, 6'd0);
    cfg_c = le_put(cfg_c, 1, 3'd4, 6'd8, 6'd3);
    cfg_c = out_put(cfg_c, 0, 6'd8);
    cfg_c = out_put(cfg_c, 1, 6'd9);
    cfg_c = out_put(cfg_c, 2, 6'd63);

    rst = 1'b1; cfg_start = 1'b0; cfg_word = '0; cfg_valid = 1'b0;
    in_valid = 1'b0; chrom_in = '0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_chrom_out", 32'(chrom_out), 0);
    check("rst_out_gen", 32'(out_gen), 0);
    check("rst_cfg_gen", 32'(cfg_gen), 0);
    check("rst_cfg_ready", 32'(cfg_ready), 0);
    check("rst_cfg_done", 32'(cfg_done), 0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", 32'(in_ready), 1);

    run_vec(8'hA5, 8'hFF, 4'd0, "zero_a5");
    run_vec(8'hA4, 8'h00, 4'd0, "zero_a4");

    load_cfg(cfg_a, 4'd1, "cfg_a");
    run_vec(8'h03, 8'h02, 4'd1, "a_03");
    run_vec(8'h01, 8'h01, 4'd1, "a_01");
    run_vec(8'hF0, 8'hF0, 4'd1, "a_f0");

    // Backpressure: two vectors fill the pipe, the third must wait.
    out_ready = 1'b0;
    in_valid = 1'b1; chrom_in = 8'h11;
    check("bp_ready1", 32'(in_ready), 1);
    tick();
    chrom_in = 8'h22;
    check("bp_ready2", 32'(in_ready), 1);
    tick();
    chrom_in = 8'h33;
    check("bp_stall", 32'(in_ready), 0);
    check("bp_head_valid", 32'(out_valid), 1);
    check("bp_head_data", 32'(chrom_out), 32'h11);
    tick(); tick();
    check("bp_still_stall", 32'(in_ready), 0);
    check("bp_hold_data", 32'(chrom_out), 32'h11);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("bp_second_data", 32'(chrom_out), 32'h23);
    check("bp_second_gen", 32'(out_gen), 1);
    tick();
    check("bp_third_data", 32'(chrom_out), 32'h32);
    check("bp_third_valid", 32'(out_valid), 1);
    tick();
    check("bp_empty", 32'(out_valid), 0);
    $display("backpressure: 11/22/33 streamed in order");

    // Reload under traffic: 10 junk words, restart, 27 words of config C.
    phase = 0; wi = 0; vi = 0; nout = 0; loaded = 1'b0; d0 = done_cnt;
    for (int c = 0; c < 400; c++) begin
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      if (phase == 0 || phase == 2) begin
        cfg_start = 1'b1;
      end else if (phase == 1) begin
        cfg_valid = 1'b1; cfg_word = 16'hFFFF;
      end else if (phase == 3) begin
        cfg_valid = 1'b1; cfg_word = cfg_c[wi*16 +: 16];
      end
      if (!in_valid && vi < NV && (c % 2 == 1)) begin
        tmp = 8'(vi * 29 + 3);
        in_valid = 1'b1;
        chrom_in = tmp;
      end
      cfg_take = cfg_valid && cfg_ready;
      vec_take = in_valid && in_ready;
      if (cfg_done) check("reload_commit_in_ready", 32'(in_ready), 0);
      if (out_valid) begin
        check("reload_q_nonempty", 32'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check("reload_data", 32'(chrom_out), 32'(e[7:0]));
          check("reload_gen", 32'(out_gen), 32'(e[11:8]));
          $display("stream out: data=%02h gen=%0d exp=%02h/%0d", chrom_out, out_gen, e[7:0], e[11:8]);
        end
        nout++;
      end
      if (vec_take) begin
        if (loaded) expq.push_back({4'd2, f_c(chrom_in)});
        else        expq.push_back({4'd1, f_a(chrom_in)});
      end
      tick();
      if (vec_take) begin in_valid = 1'b0; vi++; end
      case (phase)
        0: begin phase = 1; wi = 0; end
        1: if (cfg_take) begin wi++; if (wi == 10) phase = 2; end
        2: begin phase = 3; wi = 0; end
        3: if (cfg_take) begin
             if (wi == NW - 1) begin loaded = 1'b1; phase = 4; end
             else wi++;
           end
        default: ;
      endcase
      if (phase == 4 && vi == NV && expq.size() == 0 && !out_valid) break;
    end
    cfg_start = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0;
    check("reload_all_results", nout, NV);
    check("reload_done_pulses", done_cnt - d0, 1);
    check("reload_cfg_gen", 32'(cfg_gen), 2);
    run_vec(8'h05, 8'hFA, 4'd2, "c_05");

    load_cfg(cfg_b, 4'd3, "cfg_b");
    run_vec(8'h00, 8'h00, 4'd3, "ff_00");
    run_vec(8'h01, 8'hFF, 4'd3, "ff_01");
    run_vec(8'hFE, 8'h00, 4'd3, "ff_fe");

    // Async reset in the middle of a load with a result waiting in stage 2.
    out_ready = 1'b0;
    in_valid = 1'b1; chrom_in = 8'h01;
    tick();
    in_valid = 1'b0;
    tick();
    check("mid_pre_valid", 32'(out_valid), 1);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int w = 0; w < 13; w++) begin
      cfg_valid = 1'b1; cfg_word = cfg_a[w*16 +: 16];
      tick();
    end
    cfg_valid = 1'b0;
    check("mid_pre_cfg_ready", 32'(cfg_ready), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_cfg_gen", 32'(cfg_gen), 0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_chrom_out", 32'(chrom_out), 0);
    check("mid_rst_cfg_ready", 32'(cfg_ready), 0);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("mid_post_in_ready", 32'(in_ready), 1);
    check("mid_post_cfg_ready", 32'(cfg_ready), 0);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_word = 16'hFFFF;
    check("idle_start_cfg_ready", 32'(cfg_ready), 0);
    tick();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    run_vec(8'hA5, 8'hFF, 4'd0, "mid_a5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
